voting_tally: RTL

- Sequential, parametrised successor to the three-voter combinational voting rule.
- Runs one voting session at a time: opens on a start pulse, collects at most one ballot per voter over time, and closes when all have voted or a timeout expires.
- At close it applies a selectable decision rule (majority, unanimous, threshold) and holds the result until acknowledged.
- Sits between the voter input stage (buttons or switches, debounced upstream) and the display/result logic.

---
 rtl/voting_pkg.sv | 16 +
 rtl/voting_popcount.sv | 20 ++
 rtl/voting_tally.sv | 131 +++++++++++++
 3 files changed

// File: rtl/voting_pkg.sv
// Shared encodings for the voting tally: decision-rule codes and session states.
// Mode 2'b11 is reserved and decodes as majority wherever the rule is applied.
package voting_pkg;

    localparam logic [1:0] MODE_MAJ  = 2'b00;
    localparam logic [1:0] MODE_UNAN = 2'b01;
    localparam logic [1:0] MODE_THR  = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        DECIDE  = 2'b10,
        RESULT  = 2'b11
    } state_t;

endpackage

// File: rtl/voting_popcount.sv
// Purpose: population count of a W-bit vector.
// Latency: combinational.
// Backpressure: none; pure function of the input.
module voting_popcount #(
    parameter int W = 3
) (
    input  logic [W-1:0]             vec,
    output logic [$clog2(W+1)-1:0]   cnt
);

    localparam int CW = $clog2(W+1);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < W; i++) begin
            cnt = cnt + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/voting_tally.sv
// Purpose: one voting session at a time; tallies ballots, closes on completion or timeout, applies a rule.
// Latency: result_valid 2 cycles after the completing ballot edge, TIMEOUT_CYC+2 after start on timeout.
// Backpressure: result held until result_ack seen with result_valid; start ignored outside IDLE.
module voting_tally
    import voting_pkg::*;
#(
    parameter int N_VOTERS    = 3,
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = $clog2(N_VOTERS+1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [CNT_W-1:0]    threshold,
    input  logic [N_VOTERS-1:0] vote_valid,
    input  logic [N_VOTERS-1:0] vote_yes,
    input  logic                result_ack,
    output logic                busy,
    output logic                result_valid,
    output logic                passed,
    output logic                unanimous,
    output logic                timed_out,
    output logic [CNT_W-1:0]    yes_count,
    output logic [CNT_W-1:0]    no_count,
    output logic                dup_err
);

    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    state_t              state;
    logic [N_VOTERS-1:0] voted;
    logic [1:0]          mode_q;
    logic [CNT_W-1:0]    thr_q;
    logic [TMR_W-1:0]    timer;

    logic [N_VOTERS-1:0] acc;
    logic [N_VOTERS-1:0] acc_yes;
    logic [N_VOTERS-1:0] acc_no;
    logic [CNT_W-1:0]    acc_yes_cnt;
    logic [CNT_W-1:0]    acc_no_cnt;
    logic                all_done;
    logic                timer_exp;
    logic                pass_d;

    // Only first ballots count; repeats are flagged but never tallied.
    assign acc       = vote_valid & ~voted;
    assign acc_yes   = acc & vote_yes;
    assign acc_no    = acc & ~vote_yes;
    assign all_done  = &(voted | acc);
    assign timer_exp = (timer == TMR_W'(TIMEOUT_CYC-1));
    assign busy      = (state != IDLE);

    voting_popcount #(.W(N_VOTERS)) u_pop_yes (.vec(acc_yes), .cnt(acc_yes_cnt));
    voting_popcount #(.W(N_VOTERS)) u_pop_no  (.vec(acc_no),  .cnt(acc_no_cnt));

    always_comb begin
        pass_d = 1'b0;
        case (mode_q)
            MODE_UNAN: pass_d = (yes_count == CNT_W'(N_VOTERS));
            MODE_THR:  pass_d = (yes_count >= thr_q);
            default:   pass_d = (yes_count > CNT_W'(N_VOTERS/2));
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            voted        <= '0;
            mode_q       <= MODE_MAJ;
            thr_q        <= '0;
            timer        <= '0;
            yes_count    <= '0;
            no_count     <= '0;
            result_valid <= 1'b0;
            passed       <= 1'b0;
            unanimous    <= 1'b0;
            timed_out    <= 1'b0;
            dup_err      <= 1'b0;
        end else begin
            dup_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        voted     <= '0;
                        yes_count <= '0;
                        no_count  <= '0;
                        timer     <= '0;
                        mode_q    <= mode;
                        thr_q     <= threshold;
                        passed    <= 1'b0;
                        unanimous <= 1'b0;
                        timed_out <= 1'b0;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    voted     <= voted | acc;
                    yes_count <= yes_count + acc_yes_cnt;
                    no_count  <= no_count + acc_no_cnt;
                    timer     <= timer + 1'b1;
                    dup_err   <= |(vote_valid & voted);
                    // Completion outranks a timeout landing on the same cycle.
                    if (all_done) begin
                        timed_out <= 1'b0;
                        state     <= DECIDE;
                    end else if (timer_exp) begin
                        timed_out <= 1'b1;
                        state     <= DECIDE;
                    end
                end
                DECIDE: begin
                    passed    <= pass_d;
                    unanimous <= !timed_out &&
                                 ((yes_count == CNT_W'(N_VOTERS)) || (no_count == CNT_W'(N_VOTERS)));
                    state     <= RESULT;
                end
                default: begin
                    // result_valid trails entry to RESULT by one cycle; ack counts only once it is up.
                    if (result_valid && result_ack) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        result_valid <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
